// File: rtl/sne_evt_stream_pkg.sv
// rtl/sne_evt_stream_pkg.sv - shared types and register map for the SNE event TCDM slave
package sne_evt_stream_pkg;

  // One SNE event as carried on the TX/RX streams and the TCDM data bus
  typedef logic [31:0] evt_word_t;

  // Register select, taken from byte-address bits [3:2]
  typedef enum logic [1:0] {
    EVT_SLV_DATA   = 2'd0,
    EVT_SLV_STATUS = 2'd1,
    EVT_SLV_CTRL   = 2'd2,
    EVT_SLV_RX_THR = 2'd3
  } evt_slv_reg_e;

  // STATUS word layout
  localparam int unsigned STS_TX_EMPTY   = 0;
  localparam int unsigned STS_RX_EMPTY   = 1;
  localparam int unsigned STS_TX_FULL    = 2;
  localparam int unsigned STS_RX_OVF     = 3;
  localparam int unsigned STS_RX_CNT_LSB = 16;
  localparam int unsigned STS_TX_CNT_LSB = 24;

  // CTRL command bits (self-clearing, act only on the write cycle)
  localparam int unsigned CTRL_FLUSH_TX = 0;
  localparam int unsigned CTRL_FLUSH_RX = 1;
  localparam int unsigned CTRL_CLR_OVF  = 2;

endpackage

// File: rtl/evt_sync_fifo.sv
// rtl/evt_sync_fifo.sv - single-clock event FIFO with push/pop/flush and occupancy count
module evt_sync_fifo
  import sne_evt_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  evt_word_t              i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output evt_word_t              o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  evt_word_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A pop on empty is ignored; a push on full only lands if a pop frees the slot this cycle
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  // Head reads as zero when empty so the stream data never exposes stale storage
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  // Pointer and count update; flush overrides any push or pop in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  // Storage write, no reset needed since empty entries are never observed
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/evt_tcdm_slave.sv
// rtl/evt_tcdm_slave.sv - TCDM responder exposing the SNE TX/RX event streams as memory-mapped FIFOs
module evt_tcdm_slave
  import sne_evt_stream_pkg::*;
#(
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8,
  parameter evt_word_t   EMPTY_WORD = 32'h0000_0000
) (
  input  logic        system_clk_i,
  input  logic        system_rst_ni,
  input  logic        tcdm_req_i,
  output logic        tcdm_gnt_o,
  input  logic [31:0] tcdm_add_i,
  input  logic        tcdm_wen_i,
  input  logic [3:0]  tcdm_be_i,
  input  logic [31:0] tcdm_data_i,
  output logic [31:0] tcdm_r_data_o,
  output logic        tcdm_r_valid_o,
  output logic        evt_tx_valid_o,
  input  logic        evt_tx_ready_i,
  output logic [31:0] evt_tx_data_o,
  input  logic        evt_rx_valid_i,
  output logic        evt_rx_ready_o,
  input  logic [31:0] evt_rx_data_i,
  output logic        irq_o
);

  localparam int unsigned TX_CNT_W = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH) + 1;

  evt_slv_reg_e        w_reg;
  logic                w_gnt;
  logic                w_wr;
  logic                w_rd;
  logic                w_tx_push;
  logic                w_tx_pop;
  logic                w_tx_flush;
  logic                w_tx_full;
  logic                w_tx_empty;
  logic [TX_CNT_W-1:0] w_tx_cnt;
  evt_word_t           w_tx_head;
  logic                w_rx_push;
  logic                w_rx_pop;
  logic                w_rx_flush;
  logic                w_rx_full;
  logic                w_rx_empty;
  logic                w_rx_drop;
  logic [RX_CNT_W-1:0] w_rx_cnt;
  evt_word_t           w_rx_head;
  logic                w_ctrl_we;
  logic                w_thr_we;
  evt_word_t           w_status;
  evt_word_t           w_rd_data;
  logic                w_unused;

  logic                r_live;
  logic                r_rvalid;
  evt_word_t           r_rdata;
  logic                r_rx_ovf;
  logic [7:0]          r_rx_thr;

  assign w_reg = evt_slv_reg_e'(tcdm_add_i[3:2]);

  // Grant follows the request except for a DATA write into a full TX FIFO; r_live keeps
  // every output low while in reset and for the first edge after release
  assign w_gnt = tcdm_req_i & r_live &
                 ~(~tcdm_wen_i & (w_reg == EVT_SLV_DATA) & w_tx_full);
  assign w_wr  = w_gnt & ~tcdm_wen_i;
  assign w_rd  = w_gnt &  tcdm_wen_i;

  assign w_tx_push  = w_wr & (w_reg == EVT_SLV_DATA) & (tcdm_be_i == 4'hF);
  assign w_tx_pop   = evt_tx_valid_o & evt_tx_ready_i;
  assign w_ctrl_we  = w_wr & (w_reg == EVT_SLV_CTRL);
  assign w_thr_we   = w_wr & (w_reg == EVT_SLV_RX_THR);
  assign w_tx_flush = w_ctrl_we & tcdm_data_i[CTRL_FLUSH_TX];
  assign w_rx_flush = w_ctrl_we & tcdm_data_i[CTRL_FLUSH_RX];

  // RX never back-pressures: an event that finds the FIFO full (and no pop) is dropped
  assign w_rx_push = evt_rx_valid_i & evt_rx_ready_o;
  assign w_rx_pop  = w_rd & (w_reg == EVT_SLV_DATA);
  assign w_rx_drop = w_rx_push & w_rx_full & ~w_rx_pop;

  assign w_unused = ^{tcdm_add_i[31:4], tcdm_add_i[1:0]};

  evt_sync_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk   (system_clk_i),
    .i_rst_n (system_rst_ni),
    .i_push  (w_tx_push),
    .i_data  (tcdm_data_i),
    .i_pop   (w_tx_pop),
    .i_flush (w_tx_flush),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_cnt)
  );

  evt_sync_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk   (system_clk_i),
    .i_rst_n (system_rst_ni),
    .i_push  (w_rx_push),
    .i_data  (evt_rx_data_i),
    .i_pop   (w_rx_pop),
    .i_flush (w_rx_flush),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_cnt)
  );

  assign tcdm_gnt_o     = w_gnt;
  assign tcdm_r_valid_o = r_rvalid;
  assign tcdm_r_data_o  = r_rdata;
  assign evt_tx_valid_o = ~w_tx_empty;
  assign evt_tx_data_o  = w_tx_head;
  assign evt_rx_ready_o = r_live;
  assign irq_o          = (r_rx_thr != 8'd0) && (8'(w_rx_cnt) >= r_rx_thr);

  // STATUS word assembled from the current FIFO state
  always_comb begin
    w_status                           = '0;
    w_status[STS_TX_CNT_LSB +: 8]      = 8'(w_tx_cnt);
    w_status[STS_RX_CNT_LSB +: 8]      = 8'(w_rx_cnt);
    w_status[STS_RX_OVF]               = r_rx_ovf;
    w_status[STS_TX_FULL]              = w_tx_full;
    w_status[STS_RX_EMPTY]             = w_rx_empty;
    w_status[STS_TX_EMPTY]             = w_tx_empty;
  end

  // Read data mux; writes and ungranted cycles return zero
  always_comb begin
    w_rd_data = '0;
    if (w_rd) begin
      case (w_reg)
        EVT_SLV_DATA:   w_rd_data = w_rx_empty ? EMPTY_WORD : w_rx_head;
        EVT_SLV_STATUS: w_rd_data = w_status;
        EVT_SLV_CTRL:   w_rd_data = '0;
        EVT_SLV_RX_THR: w_rd_data = {24'd0, r_rx_thr};
        default:        w_rd_data = '0;
      endcase
    end
  end

  // Response pipeline, overflow flag, threshold register and post-reset enable
  always_ff @(posedge system_clk_i or negedge system_rst_ni) begin
    if (!system_rst_ni) begin
      r_live   <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rx_ovf <= 1'b0;
      r_rx_thr <= 8'd0;
    end else begin
      r_live   <= 1'b1;
      r_rvalid <= w_gnt;
      r_rdata  <= w_rd_data;
      if (w_ctrl_we && tcdm_data_i[CTRL_CLR_OVF]) r_rx_ovf <= 1'b0;
      if (w_rx_drop) r_rx_ovf <= 1'b1;
      if (w_thr_we) r_rx_thr <= tcdm_data_i[7:0];
    end
  end

endmodule

// File: tb/tb_evt_tcdm_slave.sv
// tb/tb_evt_tcdm_slave.sv - self-checking bench for evt_tcdm_slave
module tb_evt_tcdm_slave;

  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam logic [31:0] EW = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] r_data;
  logic        r_valid;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic        irq;

  int n_err = 0;
  int n_chk = 0;

  // behavioural model state
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  logic [31:0] tx_seen[$];
  bit          m_ovf;
  logic [7:0]  m_thr;
  bit          exp_rv;
  logic [31:0] exp_rd;
  bit          model_en = 0;
  bit          rnd_done;

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[15];

  evt_tcdm_slave #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .EMPTY_WORD(EW)) dut (
    .system_clk_i   (clk),
    .system_rst_ni  (rst_n),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be),
    .tcdm_data_i    (wdata),
    .tcdm_r_data_o  (r_data),
    .tcdm_r_valid_o (r_valid),
    .evt_tx_valid_o (tx_valid),
    .evt_tx_ready_i (tx_ready),
    .evt_tx_data_o  (tx_data),
    .evt_rx_valid_i (rx_valid),
    .evt_rx_ready_o (rx_ready),
    .evt_rx_data_i  (rx_data),
    .irq_o          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[31:24] = 8'(txq.size());
    s[23:16] = 8'(rxq.size());
    s[3]     = m_ovf;
    s[2]     = (txq.size() == TXD);
    s[1]     = (rxq.size() == 0);
    s[0]     = (txq.size() == 0);
    return s;
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_ovf  = 0;
    m_thr  = 8'd0;
    exp_rv = 0;
    exp_rd = '0;
  endtask

  // Reference model: checks outputs for this cycle, then applies the upcoming edge
  always @(negedge clk) begin
    bit          g;
    bit          rx_pop;
    bit          rx_full_eff;
    logic [1:0]  rs;
    if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
    if (model_en) begin
      rs = add[3:2];
      chk("m_rvalid", 32'(r_valid), 32'(exp_rv));
      if (exp_rv) chk("m_rdata", r_data, exp_rd);
      g = req && !(!wen && rs == 2'd0 && txq.size() == TXD);
      chk("m_gnt", 32'(gnt), 32'(g));
      chk("m_tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
      if (txq.size() != 0) chk("m_tx_data", tx_data, txq[0]);
      chk("m_irq", 32'(irq), 32'(m_thr != 0 && rxq.size() >= int'(m_thr)));

      exp_rv = g;
      exp_rd = '0;
      if (g && wen) begin
        case (rs)
          2'd0: exp_rd = (rxq.size() != 0) ? rxq[0] : EW;
          2'd1: exp_rd = m_status();
          2'd2: exp_rd = '0;
          default: exp_rd = {24'd0, m_thr};
        endcase
      end
      rx_pop      = g && wen && rs == 2'd0 && rxq.size() != 0;
      rx_full_eff = (rxq.size() == RXD) && !rx_pop;
      if (rx_pop) void'(rxq.pop_front());
      if (txq.size() != 0 && tx_ready) void'(txq.pop_front());
      if (rx_valid && !rx_full_eff) rxq.push_back(rx_data);
      if (g && !wen && rs == 2'd2) begin
        if (wdata[0]) txq.delete();
        if (wdata[1]) rxq.delete();
        if (wdata[2]) m_ovf = 0;
      end
      if (rx_valid && rx_full_eff) m_ovf = 1;
      if (g && !wen && rs == 2'd3) m_thr = wdata[7:0];
      if (g && !wen && rs == 2'd0 && be == 4'hF) txq.push_back(wdata);
    end
  end

  // One bus transaction; called at posedge+1, returns at posedge+1 of the response cycle
  task automatic bus(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                     output logic [31:0] rd, output logic rv, output int waited);
    req = 1'b1; wen = w; add = a; be = b; wdata = d; waited = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt) begin
        waited = i;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req = 1'b0; wen = 1'b1; be = 4'h0;
    rd = r_data;
    rv = r_valid;
  endtask

  task automatic rx_push(input logic [31:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  logic [31:0] rd;
  logic        rv;
  int          wt;

  initial begin
    rst_n = 1'b0; req = 1'b0; wen = 1'b1; add = '0; be = '0; wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;

    tbl[0]  = '{1'b0, 32'h0000_000C, 4'hF, 32'h0000_0105, 32'h0};
    tbl[1]  = '{1'b1, 32'h0000_000C, 4'hF, 32'h0,         32'h0000_0005};
    tbl[2]  = '{1'b1, 32'h0000_0004, 4'hF, 32'h0,         32'h0000_0003};
    tbl[3]  = '{1'b0, 32'h0000_0000, 4'h3, 32'h0000_AAAA, 32'h0};
    tbl[4]  = '{1'b1, 32'h0000_0004, 4'hF, 32'h0,         32'h0000_0003};
    tbl[5]  = '{1'b1, 32'h0000_0008, 4'hF, 32'h0,         32'h0};
    tbl[6]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0000_00AB, 32'h0};
    tbl[7]  = '{1'b1, 32'h0000_F0F4, 4'hF, 32'h0,         32'h0100_0002};
    tbl[8]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0000_0001, 32'h0};
    tbl[9]  = '{1'b1, 32'h0000_0004, 4'hF, 32'h0,         32'h0000_0003};
    tbl[10] = '{1'b1, 32'h0000_0000, 4'hF, 32'h0,         EW};
    tbl[11] = '{1'b0, 32'h0000_0004, 4'hF, 32'h0000_FFFF, 32'h0};
    tbl[12] = '{1'b1, 32'h0000_0004, 4'hF, 32'h0,         32'h0000_0003};
    tbl[13] = '{1'b0, 32'h0000_000C, 4'hF, 32'h0,         32'h0};
    tbl[14] = '{1'b1, 32'h1234_567C, 4'hF, 32'h0,         32'h0};

    // reset state
    #3;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(r_valid), 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_irq", 32'(irq), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    model_en = 1;
    chk("rx_ready_live", 32'(rx_ready), 1);

    // register map vectors
    for (int i = 0; i < 15; i++) begin
      bus(tbl[i].wen, tbl[i].addr, tbl[i].be, tbl[i].wdata, rd, rv, wt);
      chk($sformatf("tbl%0d_wait", i), 32'(wt), 0);
      chk($sformatf("tbl%0d_rvalid", i), 32'(rv), 1);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
    end

    // 1: three back-to-back writes stream out in order
    tx_seen.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus(1'b0, 32'h0, 4'hF, 32'h11 * (i + 1), rd, rv, wt);
      chk("t1_wait", 32'(wt), 0);
      chk("t1_rvalid", 32'(rv), 1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t1_tx_count", 32'(tx_seen.size()), 3);
    if (tx_seen.size() == 3) begin
      chk("t1_tx0", tx_seen[0], 32'h11);
      chk("t1_tx1", tx_seen[1], 32'h22);
      chk("t1_tx2", tx_seen[2], 32'h33);
    end

    // 2: ninth write stalls until one slot drains
    tx_ready = 1'b0;
    tx_seen.delete();
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 32'h0, 4'hF, 32'h200 + i, rd, rv, wt);
      chk("t2_wait", 32'(wt), 0);
    end
    req = 1'b1; wen = 1'b0; add = 32'h0; be = 4'hF; wdata = 32'h208;
    @(negedge clk);
    chk("t2_stall", 32'(gnt), 0);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t2_stall_ready", 32'(gnt), 0);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    chk("t2_gnt9", 32'(gnt), 1);
    @(posedge clk); #1;
    req = 1'b0;
    chk("t2_rvalid9", 32'(r_valid), 1);
    bus(1'b1, 32'h4, 4'hF, 32'h0, rd, rv, wt);
    chk("t2_status", rd, 32'h0800_0006);
    tx_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    chk("t2_tx_count", 32'(tx_seen.size()), 9);
    if (tx_seen.size() == 9) begin
      chk("t2_tx_first", tx_seen[0], 32'h200);
      chk("t2_tx_last", tx_seen[8], 32'h208);
    end

    // 3: RX overflow and read-back order
    for (int i = 0; i < 10; i++) rx_push(32'h300 + i);
    bus(1'b1, 32'h4, 4'hF, 32'h0, rd, rv, wt);
    chk("t3_status", rd, 32'h0008_0009);
    for (int i = 0; i < 9; i++) begin
      bus(1'b1, 32'h0, 4'hF, 32'h0, rd, rv, wt);
      chk($sformatf("t3_read%0d", i), rd, (i < 8) ? 32'h300 + i : EW);
    end

    // 4: threshold interrupt
    bus(1'b0, 32'hC, 4'hF, 32'h3, rd, rv, wt);
    rx_push(32'h400);
    rx_push(32'h401);
    chk("t4_irq_below", 32'(irq), 0);
    rx_push(32'h402);
    chk("t4_irq_at", 32'(irq), 1);
    bus(1'b1, 32'h0, 4'hF, 32'h0, rd, rv, wt);
    chk("t4_read", rd, 32'h400);
    chk("t4_irq_after_read", 32'(irq), 0);
    bus(1'b1, 32'h0, 4'hF, 32'h0, rd, rv, wt);
    bus(1'b1, 32'h0, 4'hF, 32'h0, rd, rv, wt);
    chk("t4_read_last", rd, 32'h402);
    bus(1'b0, 32'hC, 4'hF, 32'h0, rd, rv, wt);

    // 5: TX flush and overflow clear
    for (int i = 0; i < 4; i++) bus(1'b0, 32'h0, 4'hF, 32'h500 + i, rd, rv, wt);
    chk("t5_tx_valid", 32'(tx_valid), 1);
    bus(1'b0, 32'h8, 4'hF, 32'h1, rd, rv, wt);
    chk("t5_flushed_valid", 32'(tx_valid), 0);
    bus(1'b1, 32'h4, 4'hF, 32'h0, rd, rv, wt);
    chk("t5_status_flush", rd, 32'h0000_000B);
    bus(1'b0, 32'h8, 4'hF, 32'h4, rd, rv, wt);
    bus(1'b1, 32'h4, 4'hF, 32'h0, rd, rv, wt);
    chk("t5_status_clr", rd, 32'h0000_0003);

    // 6: asynchronous reset with TX half full and a response pending
    for (int i = 0; i < 4; i++) bus(1'b0, 32'h0, 4'hF, 32'h600 + i, rd, rv, wt);
    req = 1'b1; wen = 1'b0; add = 32'h0; be = 4'hF; wdata = 32'h6FF;
    @(negedge clk);
    @(posedge clk); #1;
    model_en = 0;
    chk("t6_pending", 32'(r_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 0);
    chk("t6_rvalid", 32'(r_valid), 0);
    chk("t6_rdata", r_data, 0);
    chk("t6_tx_valid", 32'(tx_valid), 0);
    chk("t6_tx_data", tx_data, 0);
    chk("t6_rx_ready", 32'(rx_ready), 0);
    chk("t6_irq", 32'(irq), 0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    model_en = 1;
    bus(1'b1, 32'h4, 4'hF, 32'h0, rd, rv, wt);
    chk("t6_status", rd, 32'h0000_0003);

    // randomized traffic against the model
    rnd_done = 0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          int          r;
          logic [1:0]  rs;
          logic [31:0] d;
          logic [3:0]  b;
          r  = $urandom_range(0, 9);
          rs = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
          d  = (rs == 2'd2) ? 32'($urandom_range(0, 7)) :
               (rs == 2'd3) ? 32'($urandom_range(0, 10)) : $urandom();
          b  = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'hF;
          bus(1'($urandom()), ($urandom() & 32'hFFFF_FFF3) | {28'd0, rs, 2'b00}, b, d, rd, rv, wt);
          chk("rnd_grant_bound", 32'(wt >= 0), 1);
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          tx_ready = ($urandom_range(0, 2) != 0);
          rx_valid = ($urandom_range(0, 3) == 0);
          rx_data  = $urandom();
        end
      end
    join
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("end_tx_drained", 32'(tx_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
